// File: rtl/fpu_pkg.sv
// fpu_pkg: shared stage-register state encoding and pipeline payload widths
package fpu_pkg;
  typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, TWO = 2'd2} stage_state_t;
  localparam int PRE_EX_W = 129;
  localparam int EX_MEM_W = 69;
endpackage

// File: rtl/fpu_stage_reg.sv
// fpu_stage_reg: valid/ready pipeline stage register with optional two-entry skid buffer
module fpu_stage_reg
  import fpu_pkg::*;
#(
  parameter int DATA_W        = PRE_EX_W,
  parameter bit SKID          = 1'b1,
  parameter bit CLEAR_PAYLOAD = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occupancy
);
  stage_state_t st, nxt;
  logic [DATA_W-1:0] main_q, skid_q;
  logic in_fire, out_fire, ld_main, ld_skid, promote, clr;
  assign out_valid = st != EMPTY;
  assign out_data  = main_q;
  assign occupancy = st;
  assign in_fire   = in_valid & in_ready & ~flush;
  assign out_fire  = out_valid & out_ready;
  always_comb begin
    nxt     = st;
    ld_main = 1'b0;
    ld_skid = 1'b0;
    promote = 1'b0;
    if (flush) nxt = EMPTY;
    else
      case (st)
        EMPTY: begin
          nxt     = in_fire ? ONE : EMPTY;
          ld_main = in_fire;
        end
        ONE: begin
          nxt     = in_fire ? (out_fire ? ONE : TWO) : (out_fire ? EMPTY : ONE);
          ld_main = in_fire & out_fire;
          ld_skid = in_fire & ~out_fire;
        end
        TWO: begin
          nxt     = out_fire ? ONE : TWO;
          ld_main = out_fire;
          promote = 1'b1;
        end
        default: nxt = EMPTY;
      endcase
  end
  always_ff @(posedge clk) begin
    if (rst) st <= EMPTY;
    else st <= nxt;
  end
  always_ff @(posedge clk) begin
    if (rst || clr) main_q <= '0;
    else if (ld_main) main_q <= promote ? skid_q : in_data;
  end
  always_ff @(posedge clk) begin
    if (rst || clr) skid_q <= '0;
    else if (ld_skid) skid_q <= in_data;
  end
  generate
    if (CLEAR_PAYLOAD) begin : g_clr
      assign clr = nxt == EMPTY;
    end else begin : g_keep
      assign clr = 1'b0;
    end
    // Skid variant registers in_ready so out_ready never reaches it combinationally.
    if (SKID) begin : g_skid
      logic rdy_q;
      always_ff @(posedge clk) rdy_q <= rst | (nxt != TWO);
      assign in_ready = rdy_q & ~rst;
    end else begin : g_comb
      assign in_ready = ~rst & (~out_valid | out_ready);
    end
  endgenerate
endmodule

// File: tb/tb_fpu_stage_reg.sv
// tb_fpu_stage_reg: skid and non-skid stage variants checked against queue models
module tb_fpu_stage_reg;
  logic clk = 1'b0;
  logic rst = 1'b0, flush = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
  logic [128:0] in_data = '0;
  logic ir0, ov0, ir1, ov1;
  logic [128:0] od0, od1;
  logic [1:0] oc0, oc1;
  logic [128:0] q0[$], q1[$];
  int n_chk = 0, n_fail = 0;

  always #5 clk = ~clk;

  fpu_stage_reg #(.DATA_W(129), .SKID(1'b1), .CLEAR_PAYLOAD(1'b1)) u0 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(ir0),
    .in_data(in_data), .out_valid(ov0), .out_ready(out_ready), .out_data(od0), .occupancy(oc0));
  fpu_stage_reg #(.DATA_W(129), .SKID(1'b0), .CLEAR_PAYLOAD(1'b1)) u1 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(ir1),
    .in_data(in_data), .out_valid(ov1), .out_ready(out_ready), .out_data(od1), .occupancy(oc1));

  task automatic chk(input string tag, input logic [128:0] got, input logic [128:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step(input logic iv, input logic [128:0] d, input logic ordy, input logic fl, input logic r);
    logic e0, e1;
    logic [128:0] h0, h1;
    @(negedge clk);
    in_valid = iv; in_data = d; out_ready = ordy; flush = fl; rst = r;
    #1;
    e0 = !r && q0.size() < 2;
    e1 = !r && (q1.size() == 0 || ordy);
    h0 = q0.size() > 0 ? q0[0] : '0;
    h1 = q1.size() > 0 ? q1[0] : '0;
    chk("skid_in_ready", 129'(ir0), 129'(e0));
    chk("skid_out_valid", 129'(ov0), 129'(q0.size() > 0));
    chk("skid_out_data", od0, h0);
    chk("skid_occupancy", 129'(oc0), 129'(q0.size()));
    chk("comb_in_ready", 129'(ir1), 129'(e1));
    chk("comb_out_valid", 129'(ov1), 129'(q1.size() > 0));
    chk("comb_out_data", od1, h1);
    chk("comb_occupancy", 129'(oc1), 129'(q1.size()));
    @(posedge clk);
    if (r || fl) q0.delete();
    else begin
      if (ordy && q0.size() > 0) void'(q0.pop_front());
      if (iv && e0) q0.push_back(d);
    end
    if (r || fl) q1.delete();
    else begin
      if (ordy && q1.size() > 0) void'(q1.pop_front());
      if (iv && e1) q1.push_back(d);
    end
  endtask

  initial begin
    logic [128:0] d;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    step(0, 0, 0, 0, 1);
    #2;
    chk("reset_out_valid", 129'(ov0), 0);
    chk("reset_out_data", od0, 0);
    chk("reset_in_ready_held", 129'(ir0), 0);
    for (int i = 1; i <= 8; i++) begin
      step(1, 129'(i), 1, 0, 0);
      #2;
      chk("stream_data", od0, 129'(i));
      chk("stream_valid", 129'(ov0), 1);
    end
    step(0, 0, 1, 0, 0);
    step(1, 129'hA, 0, 0, 0);
    step(1, 129'hB, 0, 0, 0);
    #2;
    chk("fill_occupancy", 129'(oc0), 2);
    chk("fill_in_ready", 129'(ir0), 0);
    chk("fill_head", od0, 129'hA);
    step(0, 0, 1, 0, 0);
    #2;
    chk("drain1_occupancy", 129'(oc0), 1);
    chk("drain1_head", od0, 129'hB);
    step(0, 0, 1, 0, 0);
    #2;
    chk("drain2_occupancy", 129'(oc0), 0);
    chk("drain2_data", od0, 0);
    step(1, 129'h1, 0, 0, 0);
    step(1, 129'h2, 0, 0, 0);
    step(1, 129'hC, 0, 1, 0);
    #2;
    chk("flush_valid", 129'(ov0), 0);
    chk("flush_occupancy", 129'(oc0), 0);
    chk("flush_data", od0, 0);
    repeat (3) step(0, 0, 1, 0, 0);
    step(1, 129'h5, 0, 0, 0);
    step(1, 129'h6, 0, 0, 0);
    step(1, 129'h6, 1, 0, 0);
    #2;
    chk("bp_accept_data", od1, 129'h6);
    chk("bp_accept_occupancy", 129'(oc1), 1);
    step(0, 0, 1, 0, 0);
    step(0, 0, 1, 0, 0);
    step(1, 129'h7, 0, 0, 0);
    step(1, 129'h8, 0, 0, 0);
    step(1, 129'h9, 0, 1, 1);
    #2;
    chk("rst_mid_valid", 129'(ov0), 0);
    chk("rst_mid_occupancy", 129'(oc0), 0);
    chk("rst_mid_data", od0, 0);
    chk("rst_mid_in_ready", 129'(ir0), 0);
    step(0, 0, 0, 0, 0);
    #2;
    chk("rst_release_in_ready", 129'(ir0), 1);
    for (int i = 0; i < 400; i++) begin
      d[31:0] = $urandom;
      d[63:32] = $urandom;
      d[95:64] = $urandom;
      d[127:96] = $urandom;
      d[128] = 1'($urandom);
      step(1'($urandom_range(3, 0) != 0), d, 1'($urandom), 1'($urandom_range(15, 0) == 0),
           1'($urandom_range(63, 0) == 0));
    end
    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end
endmodule
